// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between the requesters, the shared I2C engine and the arbiter.
// The slave modport is the arbiter's own view; master is the surrounding system.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 32
) ();
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CMD_W-1:0] cmd_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;
  logic [OWN_W-1:0]         owner;
  logic                     active;
  logic                     eng_start;
  logic [CMD_W-1:0]         eng_cmd;
  logic                     eng_abort;
  logic                     eng_busy;
  logic                     eng_done;

  modport slave (
    input  req, cmd_in, eng_busy, eng_done,
    output gnt, done, err, owner, active, eng_start, eng_cmd, eng_abort
  );

  modport master (
    output req, cmd_in, eng_busy, eng_done,
    input  gnt, done, err, owner, active, eng_start, eng_cmd, eng_abort
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of a single I2C burst engine: grants one requester at a time,
// launches the engine with its command and aborts transfers that never complete.
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CMD_W       = 32,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int TO_W        = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  i2c_bus_arbiter_if.slave      bus
);
  localparam int OWN_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_ABORT,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_owner_q, last_owner_d;
  logic [CMD_W-1:0]   eng_cmd_q, eng_cmd_d;
  logic               eng_start_q, eng_start_d;
  logic               eng_abort_q, eng_abort_d;
  logic [TO_W-1:0]    timer_q, timer_d;

  logic [CMD_W-1:0]   cmd_arr [NUM_REQ];
  logic [OWN_W-1:0]   sel;
  logic [OWN_W-1:0]   cand;
  logic               timeout_hit;
  logic               abort_clear;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign cmd_arr[g] = bus.cmd_in[g*CMD_W +: CMD_W];
  end

  // Scan from the farthest candidate inward so the last hit is the nearest after last_owner.
  always_comb begin
    sel  = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = OWN_W'((int'(last_owner_q) + i) % NUM_REQ);
      if (bus.req[cand]) begin
        sel = cand;
      end
    end
  end

  assign timeout_hit = (timer_q == TO_W'(TIMEOUT_CYC - 1));
  // The cycle carrying the abort pulse is skipped; busy is only trusted afterwards.
  assign abort_clear = !eng_abort_q && !bus.eng_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= OWN_W'(NUM_REQ - 1);
      eng_cmd_q    <= '0;
      eng_start_q  <= 1'b0;
      eng_abort_q  <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      eng_cmd_q    <= eng_cmd_d;
      eng_start_q  <= eng_start_d;
      eng_abort_q  <= eng_abort_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|bus.req) state_d = S_START;
      S_START:   state_d = S_RUN;
      S_RUN: begin
        if (bus.eng_done)     state_d = S_RELEASE;
        else if (timeout_hit) state_d = S_ABORT;
      end
      S_ABORT:   if (abort_clear) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Completion beats the watchdog when both land on the same cycle.
  always_comb begin
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = '0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    eng_cmd_d    = eng_cmd_q;
    eng_start_d  = 1'b0;
    eng_abort_d  = 1'b0;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d       = NUM_REQ'(1) << sel;
          owner_d     = sel;
          eng_cmd_d   = cmd_arr[sel];
          eng_start_d = 1'b1;
        end
      end
      S_START: timer_d = '0;
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (bus.eng_done) begin
          done_d[owner_q] = 1'b1;
          gnt_d           = '0;
        end else if (timeout_hit) begin
          err_d[owner_q] = 1'b1;
          eng_abort_d    = 1'b1;
        end
      end
      S_ABORT:   if (abort_clear) gnt_d = '0;
      S_RELEASE: last_owner_d = owner_q;
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.owner     = owner_q;
  assign bus.active    = (state_q != S_IDLE);
  assign bus.eng_start = eng_start_q;
  assign bus.eng_cmd   = eng_cmd_q;
  assign bus.eng_abort = eng_abort_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: a transaction-level requester/engine model
// predicts grants, completions, aborts and resets; a monitor pops and compares them.
module tb_i2c_bus_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int CMD_W       = 32;
  localparam int TIMEOUT_CYC = 50;
  localparam int TO_W        = 24;

  localparam int M_DONE    = 0;
  localparam int M_TIMEOUT = 1;
  localparam int M_RESET   = 2;

  typedef enum int {K_GRANT, K_DONE, K_ERR, K_FALL, K_RESET} kind_e;
  typedef struct {
    kind_e            kind;
    int               cyc;
    int               idx;
    logic [CMD_W-1:0] cmd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  i2c_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W)) bus ();

  i2c_bus_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .CMD_W      (CMD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   cyc = 0;
  bit   rst_seen = 1'b0;
  int   vectors_applied = 0;
  int   miscompares = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset_n;
  end

  // Requester/engine model state
  int                 last_owner = NUM_REQ - 1;
  logic [NUM_REQ-1:0] pending = '0;
  logic [CMD_W-1:0]   cmds [NUM_REQ];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors_applied++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic popExpect(input kind_e want, input string name, output exp_t e, output bit ok);
    e = '{K_RESET, 0, 0, '0};
    ok = 1'b0;
    if (sb.size() == 0) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL unexpected_%s at cycle %0d: got an event, expected none", name, cyc);
    end else begin
      e = sb.pop_front();
      ok = 1'b1;
      checkOutput({name, "_kind"}, 64'(int'(e.kind)), 64'(int'(want)));
    end
  endtask

  function automatic int rrPick(input int last, input logic [NUM_REQ-1:0] r);
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (r[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input int idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic push(input kind_e k, input int c, input int idx, input logic [CMD_W-1:0] cmd);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.idx  = idx;
    e.cmd  = cmd;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveReq(input logic [NUM_REQ-1:0] r);
    bus.req = r;
    for (int k = 0; k < NUM_REQ; k++) bus.cmd_in[k*CMD_W +: CMD_W] = cmds[k];
  endtask

  task automatic doReset(input int n);
    reset_n = 1'b0;
    for (int k = 1; k <= n; k++) push(K_RESET, cyc + k, 0, '0);
    tick(n);
    reset_n = 1'b1;
    last_owner = NUM_REQ - 1;
  endtask

  // Entered right after an edge with the arbiter idle; returns idle-ready again.
  task automatic applyStimulus(input int mode, input int j, input int b, input bit drop_mid,
                               input bit rereq);
    int w, g, a, fall;
    driveReq(pending);
    w = rrPick(last_owner, pending);
    g = cyc + 1;
    push(K_GRANT, g, w, cmds[w]);
    tick(1);
    bus.eng_busy = 1'b1;
    if (drop_mid) bus.req[w] = 1'b0;
    if (mode == M_DONE) begin
      tick(j);
      bus.eng_done = 1'b1;
      push(K_DONE, g + j + 1, w, cmds[w]);
      tick(1);
      bus.eng_done = 1'b0;
      bus.eng_busy = 1'b0;
      last_owner = w;
      tick(1);
    end else if (mode == M_TIMEOUT) begin
      a = g + TIMEOUT_CYC + 1;
      push(K_ERR, a, w, cmds[w]);
      tick(TIMEOUT_CYC + 1);
      tick(b);
      bus.eng_busy = 1'b0;
      bus.eng_done = 1'b1;
      fall = a + ((b < 1) ? 1 : b) + 1;
      push(K_FALL, fall, w, cmds[w]);
      tick(1);
      bus.eng_done = 1'b0;
      while (cyc < fall) tick(1);
      last_owner = w;
      tick(1);
    end else begin
      tick(j);
      reset_n = 1'b0;
      push(K_RESET, cyc + 1, 0, '0);
      tick(1);
      reset_n = 1'b1;
      bus.eng_busy = 1'b0;
      last_owner = NUM_REQ - 1;
      return;
    end
    if (rereq) cmds[w] = $urandom;
    else pending[w] = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the arbiter presents an event
  logic [NUM_REQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (rst_seen) begin
      popExpect(K_RESET, "reset", e, ok);
      if (ok) begin
        checkOutput("reset_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("reset_outputs", 64'({bus.gnt, bus.done, bus.err, bus.owner, bus.active,
                                          bus.eng_start, bus.eng_abort}), 64'(0));
        checkOutput("reset_eng_cmd", 64'(bus.eng_cmd), 64'(0));
      end
    end else begin
      checkOutput("onehot_outputs", 64'($onehot0(bus.gnt) && $onehot0(bus.done) &&
                  $onehot0(bus.err) && !((bus.done != 0) && (bus.err != 0))), 64'(1));
      if (bus.eng_start) begin
        popExpect(K_GRANT, "grant", e, ok);
        if (ok) begin
          checkOutput("grant_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("grant_gnt", 64'(bus.gnt), 64'(oneHot(e.idx)));
          checkOutput("grant_owner", 64'(bus.owner), 64'(e.idx));
          checkOutput("grant_eng_cmd", 64'(bus.eng_cmd), 64'(e.cmd));
          checkOutput("grant_active", 64'(bus.active), 64'(1));
        end
      end
      if (bus.done != 0) begin
        popExpect(K_DONE, "done", e, ok);
        if (ok) begin
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("done_bits", 64'(bus.done), 64'(oneHot(e.idx)));
          checkOutput("done_gnt_low", 64'(bus.gnt), 64'(0));
          checkOutput("done_no_abort", 64'(bus.eng_abort), 64'(0));
          checkOutput("done_eng_cmd_held", 64'(bus.eng_cmd), 64'(e.cmd));
        end
      end
      if (bus.err != 0 || bus.eng_abort) begin
        popExpect(K_ERR, "err", e, ok);
        if (ok) begin
          checkOutput("err_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("err_bits", 64'(bus.err), 64'(oneHot(e.idx)));
          checkOutput("err_abort_pulse", 64'(bus.eng_abort), 64'(1));
          checkOutput("err_gnt_held", 64'(bus.gnt), 64'(oneHot(e.idx)));
        end
      end
      if (prev_gnt != 0 && bus.gnt == 0 && bus.done == 0) begin
        popExpect(K_FALL, "abort_release", e, ok);
        if (ok) begin
          checkOutput("abort_release_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("abort_release_owner", 64'(bus.owner), 64'(e.idx));
        end
      end
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL missing_event at cycle %0d: got nothing, expected kind %0d at cycle %0d",
               cyc, int'(sb[0].kind), sb[0].cyc);
      sb.delete(0);
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    int mode, j, b, gap;
    logic [NUM_REQ-1:0] extra;
    bus.req      = '0;
    bus.cmd_in   = '0;
    bus.eng_busy = 1'b0;
    bus.eng_done = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) cmds[k] = $urandom;
    doReset(3);
    tick(4);

    $display("[TB] round-robin with all requesters held");
    pending = 4'b1111;
    for (int t = 0; t < 5; t++) applyStimulus(M_DONE, 4, 0, 1'b0, 1'b1);

    $display("[TB] single requester, spurious engine done while idle");
    driveReq('0);
    bus.eng_done = 1'b1;
    tick(1);
    bus.eng_done = 1'b0;
    tick(3);
    pending = 4'b0010;
    applyStimulus(M_DONE, 9, 0, 1'b0, 1'b0);

    $display("[TB] reset in RUN, then wrap priority");
    pending = 4'b1110;
    cmds[1] = $urandom;
    applyStimulus(M_RESET, 7, 0, 1'b0, 1'b0);
    pending = 4'b1001;
    applyStimulus(M_DONE, 3, 0, 1'b0, 1'b0);
    applyStimulus(M_DONE, 3, 0, 1'b1, 1'b0);

    $display("[TB] done/timeout tie and watchdog abort");
    pending = 4'b0100;
    applyStimulus(M_DONE, TIMEOUT_CYC, 0, 1'b0, 1'b0);
    pending = 4'b0001;
    applyStimulus(M_TIMEOUT, 0, 3, 1'b0, 1'b0);
    pending = 4'b1000;
    applyStimulus(M_TIMEOUT, 0, 0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      extra = NUM_REQ'($urandom);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (extra[k] && !pending[k]) begin
          pending[k] = 1'b1;
          cmds[k] = $urandom;
        end
      end
      if (pending == 0) begin
        pending = oneHot($urandom_range(0, NUM_REQ - 1));
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        driveReq('0);
        bus.eng_done = $urandom_range(0, 1) == 1;
        tick(1);
        bus.eng_done = 1'b0;
        tick(gap - 1);
      end
      mode = $urandom_range(0, 9);
      b = $urandom_range(0, 4);
      if (mode < 6) applyStimulus(M_DONE, $urandom_range(1, TIMEOUT_CYC - 1), 0,
                                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      else if (mode < 8) applyStimulus(M_TIMEOUT, 0, b, 1'b0, $urandom_range(0, 1) == 1);
      else if (mode == 8) applyStimulus(M_DONE, TIMEOUT_CYC, 0, 1'b0, 1'b0);
      else begin
        j = $urandom_range(1, 30);
        applyStimulus(M_RESET, j, 0, 1'b0, 1'b0);
      end
    end

    driveReq('0);
    tick(6);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL sim_time_limit: got no completion, expected finish before limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
